// File: rtl/flash_prog_ctrl_pkg.sv
// Shared types for the flash program/erase sequencer: op codes, FSM states,
// JEDEC command bytes and the per-op unlock/command step table.
package flash_ctrl_pkg;

  typedef enum logic [1:0] {
    OpProgram     = 2'b00,
    OpSectorErase = 2'b01,
    OpChipErase   = 2'b10,
    OpReset       = 2'b11
  } op_t;

  typedef enum logic [3:0] {
    StIdle,
    StArm,
    StWSetup,
    StWPulse,
    StWHold,
    StRSetup,
    StRSample,
    StCheck,
    StResetCmd,
    StDone
  } state_t;

  localparam logic [7:0] CmdAA = 8'hAA;
  localparam logic [7:0] Cmd55 = 8'h55;
  localparam logic [7:0] CmdA0 = 8'hA0;
  localparam logic [7:0] Cmd80 = 8'h80;
  localparam logic [7:0] Cmd30 = 8'h30;
  localparam logic [7:0] Cmd10 = 8'h10;
  localparam logic [7:0] CmdF0 = 8'hF0;

  typedef enum logic [1:0] {SelU1, SelU2, SelCmd} addr_sel_t;

  typedef struct packed {
    addr_sel_t  sel;
    logic [7:0] data;
  } wr_step_t;

  function automatic logic [2:0] last_step(op_t op);
    case (op)
      OpProgram: return 3'd3;
      OpReset:   return 3'd0;
      default:   return 3'd5;
    endcase
  endfunction

  // Address is returned as a selector so the table stays independent of ADDR_W.
  function automatic wr_step_t step_lookup(op_t op, logic [2:0] step, logic [7:0] prog_data);
    wr_step_t s;
    s = '{sel: SelU1, data: CmdAA};
    case (step)
      3'd1: s = '{sel: SelU2, data: Cmd55};
      3'd2: s = '{sel: SelU1, data: (op == OpProgram) ? CmdA0 : Cmd80};
      3'd3: s = (op == OpProgram) ? '{sel: SelCmd, data: prog_data} : '{sel: SelU1, data: CmdAA};
      3'd4: s = '{sel: SelU2, data: Cmd55};
      3'd5: s = (op == OpSectorErase) ? '{sel: SelCmd, data: Cmd30} : '{sel: SelU1, data: Cmd10};
      default: s = '{sel: SelU1, data: CmdAA};
    endcase
    if (op == OpReset) s = '{sel: SelCmd, data: CmdF0};
    return s;
  endfunction

endpackage

// File: rtl/flash_prog_ctrl_if.sv
// Command/status handshake between the mapper register file and the
// flash program/erase sequencer.
interface flash_prog_ctrl_if #(
  parameter int unsigned ADDR_W = 27
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_data;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready, busy, done, error
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready, busy, done, error
  );
endinterface

// File: rtl/flash_bus_cycle.sv
// Flash strobe generator: a start pulse launches a 3-cycle write
// (setup/pulse/hold) or a 2-cycle read (setup/sample).
module flash_bus_cycle
  import flash_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 27
) (
  input  logic              m2,
  input  logic              reset_n,
  input  logic              start,
  input  logic              is_read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data,
  output logic              last,
  output logic [ADDR_W-1:0] fl_addr,
  output logic [7:0]        fl_dout,
  output logic              fl_drive,
  output logic              fl_ce_n,
  output logic              fl_oe_n,
  output logic              fl_we_n
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        dout_q;

  always_comb begin
    state_d = StIdle;
    case (state_q)
      StWSetup: state_d = StWPulse;
      StWPulse: state_d = StWHold;
      StRSetup: state_d = StRSample;
      default:  state_d = StIdle;
    endcase
    // Start is only issued while idle or in the final phase, so cycles chain back to back.
    if (start) state_d = is_read ? StRSetup : StWSetup;
  end

  always_ff @(posedge m2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start) addr_q <= addr;
      if (start && !is_read) dout_q <= data;
    end
  end

  // Chip enable drops in the hold phase so CE# returns high between writes.
  assign last     = (state_q == StWHold) || (state_q == StRSample);
  assign fl_addr  = addr_q;
  assign fl_dout  = dout_q;
  assign fl_drive = (state_q == StWSetup) || (state_q == StWPulse) || (state_q == StWHold);
  assign fl_we_n  = (state_q != StWPulse);
  assign fl_oe_n  = !((state_q == StRSetup) || (state_q == StRSample));
  assign fl_ce_n  = !((state_q == StWSetup) || (state_q == StWPulse) ||
                      (state_q == StRSetup) || (state_q == StRSample));

endmodule

// File: rtl/flash_prog_ctrl.sv
// JEDEC program/erase sequencer: walks unlock/command write lists, polls DQ6/DQ5.
// Optional poll timeout enabled by defining FLASH_CTRL_TIMEOUT_EN.
module flash_prog_ctrl
  import flash_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 27,
  parameter logic [ADDR_W-1:0] UNLOCK_ADDR1   = 27'h000AAA,
  parameter logic [ADDR_W-1:0] UNLOCK_ADDR2   = 27'h000555,
  parameter logic [23:0]       TIMEOUT_CYCLES = 24'd8_000_000
) (
  input  logic              m2,
  input  logic              reset_n,
  flash_prog_ctrl_if.slave  cmd,
  output logic [ADDR_W-1:0] fl_addr,
  output logic [7:0]        fl_dout,
  input  logic [7:0]        fl_din,
  output logic              fl_drive,
  output logic              fl_ce_n,
  output logic              fl_oe_n,
  output logic              fl_we_n,
  output logic              own_bus
);

  state_t            state_q, state_d;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic [2:0]        step_q, step_d, nstep;
  logic              rd2_q, rd2_d, dq5_q, dq5_d, dq6_q, dq6_d, error_q, error_d;
  logic              accept, timeout_hit;
  logic              bus_start, bus_read, bus_last;
  logic [ADDR_W-1:0] bus_addr, wr_addr;
  logic [7:0]        bus_data;
  wr_step_t          ws;
  logic              unused_din;

  assign unused_din = ^{fl_din[7], fl_din[4:0]};

`ifdef FLASH_CTRL_TIMEOUT_EN
  logic [23:0] poll_cnt_q;

  always_ff @(posedge m2 or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt_q <= '0;
    end else if (accept) begin
      poll_cnt_q <= '0;
    end else if (state_q == StCheck && poll_cnt_q != TIMEOUT_CYCLES) begin
      poll_cnt_q <= poll_cnt_q + 24'd1;
    end
  end

  assign timeout_hit = (poll_cnt_q >= TIMEOUT_CYCLES);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    nstep = (state_q == StArm) ? 3'd0 : 3'(step_q + 3'd1);
    ws    = step_lookup(op_q, nstep, data_q);
    case (ws.sel)
      SelU1:   wr_addr = UNLOCK_ADDR1;
      SelU2:   wr_addr = UNLOCK_ADDR2;
      default: wr_addr = addr_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    rd2_d     = rd2_q;
    dq5_d     = dq5_q;
    dq6_d     = dq6_q;
    error_d   = error_q;
    accept    = 1'b0;
    bus_start = 1'b0;
    bus_read  = 1'b0;
    bus_addr  = wr_addr;
    bus_data  = ws.data;
    case (state_q)
      StIdle: begin
        if (cmd.cmd_valid) begin
          accept  = 1'b1;
          error_d = 1'b0;
          step_d  = 3'd0;
          state_d = StArm;
        end
      end
      StArm: begin
        bus_start = 1'b1;
        state_d   = StWSetup;
      end
      StWSetup: begin
        if (bus_last) begin
          if (step_q != last_step(op_q)) begin
            step_d    = nstep;
            bus_start = 1'b1;
          end else if (op_q == OpReset) begin
            state_d = StDone;
          end else begin
            bus_start = 1'b1;
            bus_read  = 1'b1;
            bus_addr  = addr_q;
            rd2_d     = 1'b0;
            dq5_d     = 1'b0;
            state_d   = StCheck;
          end
        end
      end
      StCheck: begin
        if (bus_last) begin
          bus_addr = addr_q;
          if (!rd2_q) begin
            dq6_d     = fl_din[6];
            rd2_d     = 1'b1;
            bus_start = 1'b1;
            bus_read  = 1'b1;
          end else if (dq6_q == fl_din[6]) begin
            state_d = StDone;
          end else if (dq5_q || timeout_hit) begin
            error_d   = 1'b1;
            bus_start = 1'b1;
            bus_data  = CmdF0;
            state_d   = StResetCmd;
          end else if (fl_din[5]) begin
            // DQ5 seen while toggling: one confirming re-read against this sample.
            dq5_d     = 1'b1;
            dq6_d     = fl_din[6];
            bus_start = 1'b1;
            bus_read  = 1'b1;
          end else begin
            rd2_d     = 1'b0;
            bus_start = 1'b1;
            bus_read  = 1'b1;
          end
        end
      end
      StResetCmd: if (bus_last) state_d = StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge m2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      op_q    <= OpProgram;
      addr_q  <= '0;
      data_q  <= '0;
      step_q  <= '0;
      rd2_q   <= 1'b0;
      dq5_q   <= 1'b0;
      dq6_q   <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      rd2_q   <= rd2_d;
      dq5_q   <= dq5_d;
      dq6_q   <= dq6_d;
      error_q <= error_d;
      if (accept) begin
        op_q   <= op_t'(cmd.cmd_op);
        addr_q <= cmd.cmd_addr;
        data_q <= cmd.cmd_data;
      end
    end
  end

  flash_bus_cycle #(
    .ADDR_W (ADDR_W)
  ) u_bus (
    .m2       (m2),
    .reset_n  (reset_n),
    .start    (bus_start),
    .is_read  (bus_read),
    .addr     (bus_addr),
    .data     (bus_data),
    .last     (bus_last),
    .fl_addr  (fl_addr),
    .fl_dout  (fl_dout),
    .fl_drive (fl_drive),
    .fl_ce_n  (fl_ce_n),
    .fl_oe_n  (fl_oe_n),
    .fl_we_n  (fl_we_n)
  );

  assign own_bus       = (state_q != StIdle) && (state_q != StDone);
  assign cmd.busy      = own_bus;
  assign cmd.cmd_ready = (state_q == StIdle);
  assign cmd.done      = (state_q == StDone);
  assign cmd.error     = error_q;

endmodule

// File: tb/tb_flash_prog_ctrl.sv
// Directed bench for flash_prog_ctrl with a DQ6/DQ5 flash status model.
module tb_flash_prog_ctrl;

  logic        m2 = 1'b0;
  logic        reset_n;
  logic [26:0] fl_addr;
  logic [7:0]  fl_dout;
  logic [7:0]  fl_din;
  logic        fl_drive, fl_ce_n, fl_oe_n, fl_we_n, own_bus;

  int checks = 0;
  int errors = 0;

  always #5 m2 = ~m2;

  flash_prog_ctrl_if #(.ADDR_W(27)) cmd_if ();

  flash_prog_ctrl #(
    .TIMEOUT_CYCLES (24'd100)
  ) dut (
    .m2       (m2),
    .reset_n  (reset_n),
    .cmd      (cmd_if),
    .fl_addr  (fl_addr),
    .fl_dout  (fl_dout),
    .fl_din   (fl_din),
    .fl_drive (fl_drive),
    .fl_ce_n  (fl_ce_n),
    .fl_oe_n  (fl_oe_n),
    .fl_we_n  (fl_we_n),
    .own_bus  (own_bus)
  );

  // Flash status model: read n returns DQ6 = n[0] for n < tog_reads, then holds.
  int          tog_reads = 0;
  logic        dq5_mode  = 1'b0;
  int          rd_cycles = 0;
  int          rd_base   = 0;
  int          rn_c, last_c;
  logic [26:0] cur_addr  = '0;

  always @(posedge m2) if (!fl_oe_n) rd_cycles <= rd_cycles + 1;

  always_comb begin
    rn_c   = (rd_cycles - rd_base) >>> 1;
    last_c = tog_reads - 1;
    fl_din = {1'b0, (rn_c < tog_reads) ? rn_c[0] : last_c[0], dq5_mode, 5'b0};
  end

  // Bus monitor: write log plus protocol violation counters.
  logic [26:0] wa[$];
  logic [7:0]  wd[$];
  int          v_we = 0, v_rd = 0, v_own = 0, we_falls = 0;

  always @(negedge m2) begin
    if (!fl_we_n) begin
      wa.push_back(fl_addr);
      wd.push_back(fl_dout);
      if (fl_ce_n || !fl_drive) v_we <= v_we + 1;
    end
    if (!fl_oe_n && (fl_drive || fl_addr != cur_addr)) v_rd <= v_rd + 1;
    if (!own_bus && !fl_ce_n) v_own <= v_own + 1;
  end

  always @(negedge fl_we_n) we_falls <= we_falls + 1;

  task automatic issue(input logic [1:0] op, input logic [26:0] a, input logic [7:0] d,
                       input bit hold);
    int n;
    n = 0;
    @(negedge m2);
    while (cmd_if.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge m2);
      n++;
    end
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_addr  = a;
    cmd_if.cmd_data  = d;
    @(negedge m2);
    if (!hold) cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int k, output int busy_lo);
    k = 0;
    busy_lo = 0;
    while (cmd_if.done !== 1'b1 && k < bound) begin
      if (cmd_if.busy !== 1'b1) busy_lo++;
      @(negedge m2);
      k++;
    end
    checks++;
    if (cmd_if.done !== 1'b1) begin
      errors++;
      $display("FAIL done_wait: no done within %0d cycles", bound);
      k = -1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op = 2'b00;
    cmd_if.cmd_addr = '0;
    cmd_if.cmd_data = '0;
    repeat (3) @(negedge m2);
    checks++;
    if ({fl_ce_n, fl_oe_n, fl_we_n, fl_drive} !== 4'b1110) begin
      errors++;
      $display("FAIL reset_strobes got %b exp 1110", {fl_ce_n, fl_oe_n, fl_we_n, fl_drive});
    end
    checks++;
    if ({own_bus, cmd_if.busy, cmd_if.done, cmd_if.error} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_status got %b exp 0000",
               {own_bus, cmd_if.busy, cmd_if.done, cmd_if.error});
    end
    checks++;
    if (fl_addr !== 27'h0 || fl_dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus got %h/%h exp 0/0", fl_addr, fl_dout);
    end
    reset_n = 1'b1;
    @(negedge m2);
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", cmd_if.cmd_ready);
    end
  endtask

  task automatic test_program();
    logic [26:0] ea[4] = '{27'hAAA, 27'h555, 27'hAAA, 27'h0123456};
    logic [7:0]  ed[4] = '{8'hAA, 8'h55, 8'hA0, 8'h5A};
    int w0, f0, v0, k, bl;
    tog_reads = 4; dq5_mode = 1'b0; rd_base = rd_cycles; cur_addr = 27'h0123456;
    w0 = wa.size(); f0 = we_falls; v0 = v_we + v_rd + v_own;
    issue(2'b00, 27'h0123456, 8'h5A, 1'b0);
    checks++;
    if ({own_bus, cmd_if.busy, fl_ce_n, cmd_if.cmd_ready} !== 4'b1110) begin
      errors++;
      $display("FAIL prog_arm got %b exp 1110",
               {own_bus, cmd_if.busy, fl_ce_n, cmd_if.cmd_ready});
    end
    wait_done(200, k, bl);
    checks++;
    if (k !== 25) begin
      errors++;
      $display("FAIL prog_latency got %0d exp 25", k);
    end
    checks++;
    if ({cmd_if.error, own_bus, cmd_if.busy} !== 3'b000) begin
      errors++;
      $display("FAIL prog_done_status got %b exp 000", {cmd_if.error, own_bus, cmd_if.busy});
    end
    checks++;
    if (wa.size() - w0 !== 4 || we_falls - f0 !== 4) begin
      errors++;
      $display("FAIL prog_wr_count got %0d/%0d exp 4/4", wa.size() - w0, we_falls - f0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wa[w0+i] !== ea[i] || wd[w0+i] !== ed[i]) begin
          errors++;
          $display("FAIL prog_wr%0d got %h/%h exp %h/%h", i, wa[w0+i], wd[w0+i], ea[i], ed[i]);
        end
      end
    end
    @(negedge m2);
    checks++;
    if ({cmd_if.done, cmd_if.cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL prog_after_done got %b exp 01", {cmd_if.done, cmd_if.cmd_ready});
    end
    checks++;
    if (v_we + v_rd + v_own - v0 !== 0) begin
      errors++;
      $display("FAIL prog_bus_protocol got %0d exp 0", v_we + v_rd + v_own - v0);
    end
  endtask

  task automatic test_sector_erase();
    int w0, k, bl, extra;
    tog_reads = 2; dq5_mode = 1'b0; rd_base = rd_cycles; cur_addr = 27'h0040000;
    w0 = wa.size();
    issue(2'b01, 27'h0040000, 8'h00, 1'b0);
    wait_done(200, k, bl);
    checks++;
    if (k !== 27 || bl !== 0) begin
      errors++;
      $display("FAIL se_latency_busy got %0d/%0d exp 27/0", k, bl);
    end
    checks++;
    if (wa.size() - w0 !== 6) begin
      errors++;
      $display("FAIL se_wr_count got %0d exp 6", wa.size() - w0);
    end else begin
      checks++;
      if (wa[w0+5] !== 27'h0040000 || wd[w0+5] !== 8'h30 || wd[w0+2] !== 8'h80) begin
        errors++;
        $display("FAIL se_wr_cmd got %h/%h,%h exp 0040000/30,80", wa[w0+5], wd[w0+5], wd[w0+2]);
      end
    end
    extra = 0;
    repeat (5) begin
      @(negedge m2);
      if (cmd_if.done === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL se_single_done got %0d extra exp 0", extra);
    end
  endtask

  task automatic test_dq5_fail();
    int w0, k, bl;
    tog_reads = 1000; dq5_mode = 1'b1; rd_base = rd_cycles; cur_addr = 27'h0000100;
    w0 = wa.size();
    issue(2'b00, 27'h0000100, 8'h33, 1'b0);
    wait_done(200, k, bl);
    checks++;
    if (k !== 22 || cmd_if.error !== 1'b1 || own_bus !== 1'b0) begin
      errors++;
      $display("FAIL dq5_done got k=%0d err=%b own=%b exp 22/1/0", k, cmd_if.error, own_bus);
    end
    checks++;
    if (wa.size() - w0 !== 5) begin
      errors++;
      $display("FAIL dq5_wr_count got %0d exp 5", wa.size() - w0);
    end else begin
      checks++;
      if (wa[w0+4] !== 27'h0000100 || wd[w0+4] !== 8'hF0) begin
        errors++;
        $display("FAIL dq5_f0 got %h/%h exp 0000100/f0", wa[w0+4], wd[w0+4]);
      end
    end
    repeat (3) @(negedge m2);
    checks++;
    if (cmd_if.error !== 1'b1) begin
      errors++;
      $display("FAIL dq5_sticky got %b exp 1", cmd_if.error);
    end
    // Next accept (a reset/read-array command) clears the flag.
    tog_reads = 0; dq5_mode = 1'b0; cur_addr = 27'h0000200;
    w0 = wa.size();
    issue(2'b11, 27'h0000200, 8'h00, 1'b0);
    checks++;
    if (cmd_if.error !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b exp 0", cmd_if.error);
    end
    wait_done(50, k, bl);
    checks++;
    if (k !== 4 || wa.size() - w0 !== 1 || wd[wa.size()-1] !== 8'hF0) begin
      errors++;
      $display("FAIL rst_op got k=%0d n=%0d exp 4/1", k, wa.size() - w0);
    end
  endtask

  task automatic test_async_reset();
    int w0, k, bl;
    tog_reads = 0; dq5_mode = 1'b0; rd_base = rd_cycles; cur_addr = 27'h0001234;
    issue(2'b00, 27'h0001234, 8'hC3, 1'b0);
    repeat (5) @(negedge m2);
    checks++;
    if (fl_we_n !== 1'b0 || fl_addr !== 27'h555 || fl_dout !== 8'h55) begin
      errors++;
      $display("FAIL ar_pulse got we=%b %h/%h exp 0 555/55", fl_we_n, fl_addr, fl_dout);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({fl_ce_n, fl_oe_n, fl_we_n, fl_drive, own_bus, cmd_if.busy} !== 6'b111000) begin
      errors++;
      $display("FAIL ar_immediate got %b exp 111000",
               {fl_ce_n, fl_oe_n, fl_we_n, fl_drive, own_bus, cmd_if.busy});
    end
    @(negedge m2);
    reset_n = 1'b1;
    rd_base = rd_cycles;
    w0 = wa.size();
    issue(2'b00, 27'h0001234, 8'hC3, 1'b0);
    wait_done(200, k, bl);
    checks++;
    if (k !== 17 || wa.size() - w0 !== 4) begin
      errors++;
      $display("FAIL ar_restart got k=%0d n=%0d exp 17/4", k, wa.size() - w0);
    end else begin
      checks++;
      if (wa[w0] !== 27'hAAA || wd[w0] !== 8'hAA || wd[w0+3] !== 8'hC3) begin
        errors++;
        $display("FAIL ar_step0 got %h/%h exp aaa/aa", wa[w0], wd[w0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w0, k, bl;
    tog_reads = 0; dq5_mode = 1'b0; rd_base = rd_cycles; cur_addr = 27'h0000777;
    w0 = wa.size();
    issue(2'b10, 27'h0000777, 8'h00, 1'b1);
    // Keep a different request pending for the whole chip erase.
    cmd_if.cmd_op = 2'b00; cmd_if.cmd_addr = 27'h0000888; cmd_if.cmd_data = 8'h11;
    wait_done(200, k, bl);
    checks++;
    if (k !== 23 || wa.size() - w0 !== 6) begin
      errors++;
      $display("FAIL b2b_first got k=%0d n=%0d exp 23/6", k, wa.size() - w0);
    end else begin
      checks++;
      if (wa[w0+5] !== 27'hAAA || wd[w0+5] !== 8'h10) begin
        errors++;
        $display("FAIL b2b_chip_cmd got %h/%h exp aaa/10", wa[w0+5], wd[w0+5]);
      end
    end
    @(negedge m2);
    checks++;
    if ({cmd_if.cmd_ready, cmd_if.done} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_ready got %b exp 10", {cmd_if.cmd_ready, cmd_if.done});
    end
    cur_addr = 27'h0000888;
    rd_base = rd_cycles;
    @(negedge m2);
    cmd_if.cmd_valid = 1'b0;
    checks++;
    if ({cmd_if.cmd_ready, cmd_if.busy} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_accept got %b exp 01", {cmd_if.cmd_ready, cmd_if.busy});
    end
    wait_done(200, k, bl);
    checks++;
    if (k !== 17 || wa.size() - w0 !== 10 || wd[wa.size()-1] !== 8'h11) begin
      errors++;
      $display("FAIL b2b_second got k=%0d n=%0d exp 17/10", k, wa.size() - w0);
    end
  endtask

`ifdef FLASH_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int k, bl;
    tog_reads = 100000; dq5_mode = 1'b0; rd_base = rd_cycles; cur_addr = 27'h0000300;
    issue(2'b00, 27'h0000300, 8'h44, 1'b0);
    wait_done(400, k, bl);
    checks++;
    if (k < 110 || k > 125 || cmd_if.error !== 1'b1 || wd[wa.size()-1] !== 8'hF0) begin
      errors++;
      $display("FAIL timeout got k=%0d err=%b exp ~118/1", k, cmd_if.error);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_program();
    test_sector_erase();
    test_dq5_fail();
    test_async_reset();
    test_back_to_back();
`ifdef FLASH_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
